// File: rtl/pattern_scan_arbiter_if.sv
// Request/result bundle between the requesters, the result consumer and pattern_scan_arbiter.
// Config fields are sampled only at grant; the result holds until res_valid && res_ready.
interface pattern_scan_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int IDW = $clog2(NREQ);
  localparam int PLW = $clog2(MAX_LEN + 1);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    din;
  logic [MAX_LEN-1:0] pattern;
  logic [PLW-1:0]     pat_len;
  logic [CNT_W-1:0]   frame_len;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic [CNT_W-1:0]   res_count;
  logic               res_abort;

  modport master (
    output req, din, pattern, pat_len, frame_len, res_ready,
    input  gnt, busy, res_valid, res_id, res_count, res_abort
  );

  modport slave (
    input  req, din, pattern, pat_len, frame_len, res_ready,
    output gnt, busy, res_valid, res_id, res_count, res_abort
  );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// Round-robin grants one serial stream at a time and counts pattern matches over a frame.
// Grant one edge after req; result valid on the last-sample edge; REPORT holds until res_ready.
module pattern_scan_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pattern_scan_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PLW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     id_q;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     cand;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] sr_q;
  logic [MAX_LEN-1:0] sr_next;
  logic [MAX_LEN-1:0] mask;
  logic [PLW-1:0]     pl_q;
  logic [PLW-1:0]     pl_in;
  logic [CNT_W-1:0]   fl_q;
  logic [CNT_W-1:0]   fl_in;
  logic [CNT_W-1:0]   bits_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               abort_q;
  logic               req_hold;
  logic               hit;
  logic               last_bit;

  // Scan downward so the requester closest to rr_ptr (offset 0) wins.
  always_comb begin
    win  = rr_ptr_q;
    cand = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (bus.req[cand]) win = cand;
    end
  end

  always_comb begin
    pl_in = bus.pat_len;
    if (bus.pat_len < PLW'(2))
      pl_in = PLW'(2);
    else if (int'(bus.pat_len) > MAX_LEN)
      pl_in = PLW'(MAX_LEN);
    fl_in = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(pl_q));
  end

  assign req_hold = bus.req[id_q];
  assign sr_next  = {sr_q[MAX_LEN-2:0], bus.din[id_q]};
  assign hit      = (((sr_next ^ pat_q) & mask) == '0) &&
                    ((int'(bits_q) + 1) >= int'(pl_q));
  assign last_bit = (int'(bits_q) + 1) == int'(fl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A dropped request wins over the last bit: the abort branch is checked first.
  always_comb begin
    state_d       = state_q;
    bus.gnt       = '0;
    bus.busy      = 1'b1;
    bus.res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (|bus.req) state_d = SCAN;
      end
      SCAN: begin
        bus.gnt[id_q] = 1'b1;
        if (!req_hold || last_bit) state_d = REPORT;
      end
      REPORT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      pat_q    <= '0;
      pl_q     <= PLW'(2);
      fl_q     <= CNT_W'(1);
      sr_q     <= '0;
      bits_q   <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            id_q    <= win;
            pat_q   <= bus.pattern;
            pl_q    <= pl_in;
            fl_q    <= fl_in;
            sr_q    <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
          end
        end
        SCAN: begin
          if (!req_hold) begin
            abort_q <= 1'b1;
          end else begin
            sr_q   <= sr_next;
            bits_q <= bits_q + 1'b1;
            if (hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
          end
        end
        REPORT: begin
          if (bus.res_ready)
            rr_ptr_q <= (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.res_id    = id_q;
  assign bus.res_count = cnt_q;
  assign bus.res_abort = abort_q;
endmodule
